// File: rtl/ttt_game_ctrl.sv
// ttt_game_ctrl: tic-tac-toe turn controller owning the board, with score/restart strobes and move checking
//   clk, reset (async, active-high) | sel[3:0], place, new_game | win1, win2, draw, inval from datapath
//   p1/p2[0:8] board masks (bit i = cell i) | en1/en2 score pulses, restart strobe, turn, game_over, move_err
module ttt_game_ctrl #(
  parameter bit FIRST_PLAYER = 1'b0,
  parameter int RESTART_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sel,
  input  logic       place,
  input  logic       new_game,
  input  logic       win1,
  input  logic       win2,
  input  logic       draw,
  input  logic       inval,
  output logic [0:8] p1,
  output logic [0:8] p2,
  output logic       en1,
  output logic       en2,
  output logic       restart,
  output logic       turn,
  output logic       game_over,
  output logic       move_err
);
  localparam int CW = RESTART_CYCLES > 1 ? $clog2(RESTART_CYCLES) : 1;
  typedef enum logic [1:0] {PLAY, CHECK, OVER, CLEAR} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [0:8] p1_d, p2_d, mask;
  logic [0:15] hot;
  logic turn_d, en1_d, en2_d, err_d, legal;
  // one-hot cell decode; indices 9..15 are treated as permanently occupied so they are rejected
  assign hot = 16'h8000 >> sel;
  assign mask = hot[0:8];
  assign legal = ~|(hot & {p1 | p2, 7'h7f});
  assign game_over = state == OVER;
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    p1_d = p1;
    p2_d = p2;
    turn_d = turn;
    en1_d = 1'b0;
    en2_d = 1'b0;
    err_d = 1'b0;
    case (state)
      PLAY:
        if (new_game) state_d = CLEAR;
        else if (place && legal) begin
          p1_d = turn ? p1 : p1 | mask;
          p2_d = turn ? p2 | mask : p2;
          state_d = CHECK;
        end else err_d = place;
      CHECK: begin
        // simultaneous wins or an invalid board end the game without a score; a win outranks draw
        en1_d = !inval && win1 && !win2;
        en2_d = !inval && win2 && !win1;
        state_d = (inval || win1 || win2 || draw) ? OVER : PLAY;
        turn_d = (inval || win1 || win2 || draw) ? turn : !turn;
      end
      OVER:
        if (new_game) state_d = CLEAR;
        else err_d = place;
      CLEAR:
        if (cnt == CW'(RESTART_CYCLES - 1)) state_d = PLAY;
        else cnt_d = cnt + 1'b1;
      default: state_d = PLAY;
    endcase
    if (state != CLEAR && state_d == CLEAR) begin
      p1_d = '0;
      p2_d = '0;
      turn_d = FIRST_PLAYER;
      cnt_d = '0;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= PLAY;
      cnt <= '0;
      p1 <= '0;
      p2 <= '0;
      turn <= FIRST_PLAYER;
      en1 <= 1'b0;
      en2 <= 1'b0;
      restart <= 1'b0;
      move_err <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      p1 <= p1_d;
      p2 <= p2_d;
      turn <= turn_d;
      en1 <= en1_d;
      en2 <= en2_d;
      restart <= state_d == CLEAR;
      move_err <= err_d;
    end
endmodule

// File: tb/tb_ttt_game_ctrl.sv
// tb_ttt_game_ctrl: vector-table and scoreboard bench for ttt_game_ctrl with a behavioural datapath
module tb_ttt_game_ctrl;
  logic clk = 1'b0, reset = 1'b0, place = 1'b0, new_game = 1'b0, inval_ovr = 1'b0;
  logic [3:0] sel = '0;
  logic win1, win2, draw, inval, en1, en2, restart, turn, game_over, move_err;
  logic [0:8] p1, p2;
  logic [22:0] outs;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  ttt_game_ctrl dut (.clk(clk), .reset(reset), .sel(sel), .place(place), .new_game(new_game),
    .win1(win1), .win2(win2), .draw(draw), .inval(inval), .p1(p1), .p2(p2), .en1(en1), .en2(en2),
    .restart(restart), .turn(turn), .game_over(game_over), .move_err(move_err));
  function automatic logic line(logic [0:8] b);
    int l[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    for (int i = 0; i < 8; i++)
      if (b[l[i][0]] && b[l[i][1]] && b[l[i][2]]) return 1'b1;
    return 1'b0;
  endfunction
  assign win1 = line(p1);
  assign win2 = line(p2);
  assign draw = &(p1 | p2);
  assign inval = |(p1 & p2) | inval_ovr;
  assign outs = {p1, p2, turn, en1, en2, restart, game_over, move_err};
  function automatic logic [0:8] c(int i);
    return 9'b100000000 >> i;
  endfunction
  typedef struct {
    logic ng, pl;
    logic [3:0] sel;
    logic inv;
    logic [0:8] p1, p2;
    logic turn, en1, en2, rst, over, err;
  } vec_t;
  vec_t tbl[$];
  logic [22:0] sb[$];
  logic [0:8] m_p1 = '0, m_p2 = '0;
  logic m_turn = 1'b0, m_over = 1'b0;
  task automatic chk(input string name, input logic [22:0] got, input logic [22:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b exp %b", name, got, exp);
    end
  endtask
  task automatic push(input logic ng, pl, input logic [3:0] s, input logic inv, e1, e2, rs, er);
    tbl.push_back('{ng, pl, s, inv, m_p1, m_p2, m_turn, e1, e2, rs, m_over, er});
  endtask
  task automatic mv(input int s, input int outc, input logic inv = 1'b0);
    if (m_turn) m_p2 |= c(s);
    else m_p1 |= c(s);
    push(1'b0, 1'b1, 4'(s), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    m_over = outc != 0;
    if (outc == 0) m_turn = ~m_turn;
    push(1'b0, 1'b0, 4'd0, inv, outc == 1, outc == 2, 1'b0, 1'b0);
  endtask
  task automatic ng_seq(input logic with_place);
    m_p1 = '0; m_p2 = '0; m_turn = 1'b0; m_over = 1'b0;
    push(1'b1, with_place, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push(1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic bad(input int s);
    push(1'b0, 1'b1, 4'(s), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  initial begin
    int seen;
    mv(4, 0); mv(0, 0);
    ng_seq(1'b1);
    mv(0, 0); mv(3, 0); mv(1, 0); mv(4, 0); mv(2, 1);
    push(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bad(8);
    ng_seq(1'b0);
    mv(4, 0); bad(4); bad(12); bad(9);
    ng_seq(1'b0);
    mv(0, 0); mv(1, 0); mv(2, 0); mv(4, 0); mv(3, 0); mv(5, 0); mv(7, 0); mv(6, 0); mv(8, 3);
    ng_seq(1'b0);
    mv(1, 0); mv(2, 0); mv(4, 0); mv(3, 0); mv(5, 0); mv(6, 0); mv(0, 0); mv(7, 0); mv(8, 1);
    ng_seq(1'b0);
    mv(0, 0); mv(3, 0); mv(1, 0); mv(4, 0); mv(8, 0); mv(5, 2);
    ng_seq(1'b0);
    mv(0, 3, 1'b1);
    ng_seq(1'b0);
    m_p1 |= c(0);
    push(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    m_turn = 1'b1;
    push(1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #2 chk("reset_state", outs, 23'd0);
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      new_game = tbl[i].ng; place = tbl[i].pl; sel = tbl[i].sel; inval_ovr = tbl[i].inv;
      sb.push_back({tbl[i].p1, tbl[i].p2, tbl[i].turn, tbl[i].en1, tbl[i].en2, tbl[i].rst,
                    tbl[i].over, tbl[i].err});
      @(posedge clk);
      #1 chk($sformatf("vec%0d", i), outs, sb.pop_front());
    end
    @(negedge clk) begin new_game = 1'b0; place = 1'b0; inval_ovr = 1'b0; reset = 1'b1; end
    @(negedge clk) reset = 1'b0;
    foreach (tbl[i]) if (i < 4) begin
      @(negedge clk) begin place = 1'b1; sel = 4'(i == 0 ? 0 : i == 1 ? 3 : i == 2 ? 1 : 4); end
      @(negedge clk) place = 1'b0;
    end
    @(negedge clk) begin place = 1'b1; sel = 4'd2; end
    @(posedge clk);
    #1 place = 1'b0;
    chk("win_move_board", {p1, p2}, {c(0) | c(1) | c(2), c(3) | c(4)});
    #2 reset = 1'b1;
    #1 chk("async_reset", outs, 23'd0);
    @(posedge clk);
    #1 chk("reset_held", outs, 23'd0);
    @(negedge clk) reset = 1'b0;
    seen = 0;
    repeat (4) begin
      @(posedge clk);
      #1 seen += int'(en1) + int'(game_over);
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL lost_en1 got %0d exp 0", seen);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
